// File: rtl/issue_buffer.sv
// Per-lane issue FIFOs between reservation-station issue and the functional units.
// Operands are captured at enqueue. Define ISSUE_BUFFER_BYPASS_EN to enable writeback bypass.
module issue_buffer #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned FUN_W    = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned AUX_W    = 3,
  parameter int unsigned IMM_W    = 12,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned XLEN     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  output logic [WIDTH-1:0]                      rs_avail,
  input  logic [WIDTH-1:0]                      rs_valid,
  input  logic [WIDTH-1:0]                      rs_opi,
  input  logic [WIDTH-1:0][FUN_W-1:0]           rs_fun,
  input  logic [WIDTH-1:0][1:0][SEL_W-1:0]      rs_sel,
  input  logic [WIDTH-1:0][AUX_W-1:0]           rs_aux,
  input  logic [WIDTH-1:0][IMM_W-1:0]           rs_imm,
  input  logic [WIDTH-1:0][1:0][PREG_W-1:0]     rs_src,
  input  logic [WIDTH-1:0][PREG_W-1:0]          rs_dst,
  output logic [WIDTH-1:0]                      rf_valid,
  output logic [WIDTH-1:0][1:0][PREG_W-1:0]     rf_src,
  input  logic [WIDTH-1:0][1:0][XLEN-1:0]       rf_ops,
  input  logic [WB_PORTS-1:0]                   wb_valid,
  input  logic [WB_PORTS-1:0][PREG_W-1:0]       wb_dst,
  input  logic [WB_PORTS-1:0][XLEN-1:0]         wb_data,
  input  logic [WIDTH-1:0]                      fu_avail,
  output logic [WIDTH-1:0]                      fu_valid,
  output logic [WIDTH-1:0]                      fu_opi,
  output logic [WIDTH-1:0][FUN_W-1:0]           fu_fun,
  output logic [WIDTH-1:0][1:0][SEL_W-1:0]      fu_sel,
  output logic [WIDTH-1:0][AUX_W-1:0]           fu_aux,
  output logic [WIDTH-1:0][IMM_W-1:0]           fu_imm,
  output logic [WIDTH-1:0][PREG_W-1:0]          fu_dst,
  output logic [WIDTH-1:0][1:0][XLEN-1:0]       fu_ops,
  output logic [WIDTH-1:0][$clog2(DEPTH+1)-1:0] lane_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic                   opi;
    logic [FUN_W-1:0]       fun;
    logic [1:0][SEL_W-1:0]  sel;
    logic [AUX_W-1:0]       aux;
    logic [IMM_W-1:0]       imm;
    logic [PREG_W-1:0]      dst;
    logic [1:0][XLEN-1:0]   ops;
  } entry_t;

  entry_t                        mem_q [WIDTH][DEPTH];
  entry_t                        wentry [WIDTH];
  logic [WIDTH-1:0][PTR_W-1:0]   wr_q, rd_q;
  logic [WIDTH-1:0][CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]              push, pop;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign rs_avail[i] = (cnt_q[i] != CNT_W'(DEPTH)) & ~flush;
    assign fu_valid[i] = (cnt_q[i] != '0);
    assign fu_opi[i]   = mem_q[i][rd_q[i]].opi;
    assign fu_fun[i]   = mem_q[i][rd_q[i]].fun;
    assign fu_sel[i]   = mem_q[i][rd_q[i]].sel;
    assign fu_aux[i]   = mem_q[i][rd_q[i]].aux;
    assign fu_imm[i]   = mem_q[i][rd_q[i]].imm;
    assign fu_dst[i]   = mem_q[i][rd_q[i]].dst;
    assign fu_ops[i]   = mem_q[i][rd_q[i]].ops;

`ifndef SYNTHESIS
    // A flush legitimately discards the pending push; anything else is an RS protocol slip.
    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
      !(rs_valid[i] && !rs_avail[i] && !flush))
      else $warning("issue_buffer: lane %0d packet dropped while lane busy", i);
`endif
  end

  assign push     = rs_valid & rs_avail;
  assign pop      = fu_valid & fu_avail;
  assign rf_valid = push;
  assign rf_src   = rs_src;
  assign lane_cnt = cnt_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      wentry[i]     = '0;
      wentry[i].opi = rs_opi[i];
      wentry[i].fun = rs_fun[i];
      wentry[i].sel = rs_sel[i];
      wentry[i].aux = rs_aux[i];
      wentry[i].imm = rs_imm[i];
      wentry[i].dst = rs_dst[i];
      for (int j = 0; j < 2; j++) begin
        wentry[i].ops[j] = rf_ops[i][j];
`ifdef ISSUE_BUFFER_BYPASS_EN
        // Scan high-to-low so the lowest matching port overrides.
        for (int k = int'(WB_PORTS) - 1; k >= 0; k--) begin
          if (wb_valid[k] && (wb_dst[k] == rs_src[i][j])) wentry[i].ops[j] = wb_data[k];
        end
`endif
      end
    end
  end

`ifndef ISSUE_BUFFER_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_dst, wb_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
        if (pop[i])  rd_q[i] <= rd_q[i] + 1'b1;
        if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (pop[i] && !push[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // Payload storage is intentionally not reset; validity lives in cnt_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= wentry[i];
    end
  end

endmodule

// File: tb/tb_issue_buffer.sv
// Self-checking bench for issue_buffer: directed sequences, a vector table and a
// randomized run against a queue-based reference model.
module tb_issue_buffer;
  localparam int W = 3;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n, flush;
  logic [W-1:0] rs_avail, rs_valid, rs_opi, rf_valid, fu_avail, fu_valid, fu_opi;
  logic [W-1:0][3:0] rs_fun, fu_fun;
  logic [W-1:0][1:0][1:0] rs_sel, fu_sel;
  logic [W-1:0][2:0] rs_aux, fu_aux;
  logic [W-1:0][11:0] rs_imm, fu_imm;
  logic [W-1:0][1:0][5:0] rs_src, rf_src;
  logic [W-1:0][5:0] rs_dst, fu_dst;
  logic [W-1:0][1:0][31:0] rf_ops, fu_ops;
  logic [1:0] wb_valid;
  logic [1:0][5:0] wb_dst;
  logic [1:0][31:0] wb_data;
  logic [W-1:0][1:0] lane_cnt;

  issue_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rs_avail(rs_avail), .rs_valid(rs_valid),
    .rs_opi(rs_opi), .rs_fun(rs_fun), .rs_sel(rs_sel), .rs_aux(rs_aux), .rs_imm(rs_imm),
    .rs_src(rs_src), .rs_dst(rs_dst), .rf_valid(rf_valid), .rf_src(rf_src), .rf_ops(rf_ops),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .fu_avail(fu_avail),
    .fu_valid(fu_valid), .fu_opi(fu_opi), .fu_fun(fu_fun), .fu_sel(fu_sel), .fu_aux(fu_aux),
    .fu_imm(fu_imm), .fu_dst(fu_dst), .fu_ops(fu_ops), .lane_cnt(lane_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; rs_valid = '0; rs_opi = '0; rs_fun = '0; rs_sel = '0; rs_aux = '0;
    rs_imm = '0; rs_src = '0; rs_dst = '0; rf_ops = '0; wb_valid = '0; wb_dst = '0;
    wb_data = '0; fu_avail = '0;
  endtask

  task automatic set_pkt(input int lane, input int dst, input int s0, input int s1,
                         input int op0, input int op1);
    rs_valid[lane] = 1'b1;
    rs_dst[lane] = 6'(dst);
    rs_src[lane][0] = 6'(s0);
    rs_src[lane][1] = 6'(s1);
    rf_ops[lane][0] = 32'(op0);
    rf_ops[lane][1] = 32'(op1);
  endtask

  typedef struct {
    logic v;
    logic a;
    logic exp_rf;
    int   exp_cnt;
  } vec_t;
  vec_t tbl [9];

  typedef logic [93:0] pkt_t;
  pkt_t mq [W][$];

  initial begin
    logic exp_by;
    logic [W-1:0] av_m, push_m, fv_m;
    logic [W-1:0][1:0] cnt_m;
    pkt_t pk [W];
    logic fl;

    // Lane 0 occupancy walk: {rs_valid, fu_avail, expected rf_valid, expected cnt after}
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 2};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 0};

    clear_inputs();
    rst_n = 1'b0;
    #3;
    check("reset_fu_valid", 128'(fu_valid), 128'(3'b000));
    check("reset_rs_avail", 128'(rs_avail), 128'(3'b111));
    check("reset_lane_cnt", 128'(lane_cnt), 128'(0));
    cyc(); cyc();
    rst_n = 1'b1;

    // First push and operand capture
    clear_inputs(); set_pkt(0, 1, 5, 6, 'h11, 'h22); #2;
    check("first_rf_valid", 128'(rf_valid), 128'(3'b001));
    check("first_rf_src", 128'(rf_src[0]), 128'({6'd6, 6'd5}));
    check("first_fu_valid_same_cycle", 128'(fu_valid), 128'(3'b000));
    cyc();
    clear_inputs(); fu_avail[0] = 1'b1; #2;
    check("first_fu_valid", 128'(fu_valid), 128'(3'b001));
    check("first_op0", 128'(fu_ops[0][0]), 128'(32'h11));
    check("first_op1", 128'(fu_ops[0][1]), 128'(32'h22));
    cyc();
    clear_inputs(); #2;
    check("first_drained", 128'(lane_cnt[0]), 128'(0));

    // Table-driven occupancy vectors
    for (int r = 0; r < 9; r++) begin
      clear_inputs();
      if (tbl[r].v) set_pkt(0, r, 0, 0, r, r);
      fu_avail[0] = tbl[r].a;
      #2;
      check($sformatf("tbl%0d_rf_valid", r), 128'(rf_valid[0]), 128'(tbl[r].exp_rf));
      cyc();
      clear_inputs(); #1;
      check($sformatf("tbl%0d_cnt", r), 128'(lane_cnt[0]), 128'(tbl[r].exp_cnt));
    end

    // Backpressure on lane 1
    clear_inputs(); set_pkt(1, 7, 0, 0, 0, 0); #2; cyc();
    clear_inputs(); set_pkt(1, 8, 0, 0, 0, 0); #2; cyc();
    clear_inputs(); set_pkt(1, 9, 0, 0, 0, 0); #2;
    check("bp_cnt_full", 128'(lane_cnt[1]), 128'(2));
    check("bp_rs_avail", 128'(rs_avail[1]), 128'(0));
    check("bp_drop_rf_valid", 128'(rf_valid[1]), 128'(0));
    cyc();
    clear_inputs(); fu_avail[1] = 1'b1; #2;
    check("bp_cnt_after_drop", 128'(lane_cnt[1]), 128'(2));
    check("bp_head_dst7", 128'(fu_dst[1]), 128'(7));
    cyc();
    clear_inputs(); fu_avail[1] = 1'b1; #2;
    check("bp_head_dst8", 128'(fu_dst[1]), 128'(8));
    cyc();
    clear_inputs(); #2;
    check("bp_empty_cnt", 128'(lane_cnt[1]), 128'(0));
    check("bp_rs_avail_back", 128'(rs_avail[1]), 128'(1));
    check("bp_fu_valid", 128'(fu_valid[1]), 128'(0));

    // Simultaneous push/pop on lane 2, pointer wrap
    clear_inputs(); set_pkt(2, 0, 0, 0, 0, 0); #2; cyc();
    for (int n = 1; n < 10; n++) begin
      clear_inputs(); set_pkt(2, n, 0, 0, 0, 0); fu_avail[2] = 1'b1; #2;
      check($sformatf("pp%0d_dst", n), 128'(fu_dst[2]), 128'(n - 1));
      check($sformatf("pp%0d_cnt", n), 128'(lane_cnt[2]), 128'(1));
      cyc();
    end
    clear_inputs(); fu_avail[2] = 1'b1; #2;
    check("pp_last_dst", 128'(fu_dst[2]), 128'(9));
    cyc();
    clear_inputs(); #2;
    check("pp_empty", 128'(lane_cnt[2]), 128'(0));

    // Flush with all lanes full and pushes pending
    for (int s = 0; s < 2; s++) begin
      clear_inputs();
      for (int l = 0; l < W; l++) set_pkt(l, 16 * (s + 1) + l, 0, 0, 0, 0);
      #2; cyc();
    end
    clear_inputs(); #2;
    check("fl_full_cnt", 128'(lane_cnt), 128'({2'd2, 2'd2, 2'd2}));
    for (int l = 0; l < W; l++) set_pkt(l, 40 + l, 0, 0, 0, 0);
    flush = 1'b1; #1;
    check("fl_rf_valid", 128'(rf_valid), 128'(0));
    check("fl_rs_avail", 128'(rs_avail), 128'(0));
    cyc();
    clear_inputs(); #2;
    check("fl_cnt", 128'(lane_cnt), 128'(0));
    check("fl_fu_valid", 128'(fu_valid), 128'(0));
    set_pkt(0, 'h33, 0, 0, 0, 0); #1; cyc();
    clear_inputs(); #2;
    check("fl_post_cnt", 128'(lane_cnt[0]), 128'(1));
    check("fl_post_dst", 128'(fu_dst[0]), 128'('h33));
    fu_avail[0] = 1'b1; cyc();

    // Writeback bypass at capture
    clear_inputs(); set_pkt(0, 1, 9, 3, 'hAA, 'hBB);
    wb_valid = 2'b11; wb_dst[0] = 6'd9; wb_dst[1] = 6'd9;
    wb_data[0] = 32'h55; wb_data[1] = 32'h66;
    #2; cyc();
    clear_inputs(); #2;
`ifdef ISSUE_BUFFER_BYPASS_EN
    check("byp_op0", 128'(fu_ops[0][0]), 128'(32'h55));
`else
    check("byp_op0", 128'(fu_ops[0][0]), 128'(32'hAA));
`endif
    check("byp_op1", 128'(fu_ops[0][1]), 128'(32'hBB));
    fu_avail[0] = 1'b1; cyc();

    // Randomized run against the queue model
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      fl = ($urandom_range(31) == 0);
      flush = fl;
      wb_valid = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        wb_dst[k] = 6'($urandom_range(7));
        wb_data[k] = $urandom;
      end
      for (int i = 0; i < W; i++) begin
        av_m[i] = (mq[i].size() != D) && !fl;
        rs_valid[i] = fl ? 1'($urandom_range(1)) : (av_m[i] && ($urandom_range(2) != 0));
        rs_opi[i] = 1'($urandom); rs_fun[i] = 4'($urandom); rs_sel[i] = 4'($urandom);
        rs_aux[i] = 3'($urandom); rs_imm[i] = 12'($urandom); rs_dst[i] = 6'($urandom);
        for (int j = 0; j < 2; j++) begin
          rs_src[i][j] = 6'($urandom_range(7));
          rf_ops[i][j] = $urandom;
        end
        fu_avail[i] = 1'($urandom_range(1));
        push_m[i] = rs_valid[i] && av_m[i];
        fv_m[i] = (mq[i].size() != 0);
        cnt_m[i] = 2'(mq[i].size());
        pk[i] = {rs_opi[i], rs_fun[i], rs_sel[i], rs_aux[i], rs_imm[i], rs_dst[i],
                 rf_ops[i][1], rf_ops[i][0]};
`ifdef ISSUE_BUFFER_BYPASS_EN
        for (int j = 0; j < 2; j++) begin
          exp_by = 1'b0;
          for (int k = 0; k < 2; k++) begin
            if (!exp_by && wb_valid[k] && wb_dst[k] == rs_src[i][j]) begin
              exp_by = 1'b1;
              pk[i][32*j +: 32] = wb_data[k];
            end
          end
        end
`endif
      end
      #2;
      check($sformatf("rnd%0d_rs_avail", c), 128'(rs_avail), 128'(av_m));
      check($sformatf("rnd%0d_rf_valid", c), 128'(rf_valid), 128'(push_m));
      check($sformatf("rnd%0d_fu_valid", c), 128'(fu_valid), 128'(fv_m));
      check($sformatf("rnd%0d_lane_cnt", c), 128'(lane_cnt), 128'(cnt_m));
      for (int i = 0; i < W; i++) begin
        if (mq[i].size() != 0)
          check($sformatf("rnd%0d_head%0d", c, i),
                128'({fu_opi[i], fu_fun[i], fu_sel[i], fu_aux[i], fu_imm[i], fu_dst[i],
                      fu_ops[i]}), 128'(mq[i][0]));
      end
      for (int i = 0; i < W; i++) begin
        if (fl) mq[i].delete();
        else begin
          if (fu_avail[i] && mq[i].size() != 0) void'(mq[i].pop_front());
          if (push_m[i]) mq[i].push_back(pk[i]);
        end
      end
      cyc();
    end

    // Asynchronous reset mid-stream, no clock edge involved
    clear_inputs(); flush = 1'b1; cyc();
    clear_inputs(); set_pkt(0, 1, 0, 0, 0, 0); #2; cyc();
    clear_inputs(); set_pkt(0, 2, 0, 0, 0, 0); #2; cyc();
    clear_inputs(); #2;
    check("ar_pre_cnt", 128'(lane_cnt[0]), 128'(2));
    rst_n = 1'b0; #1;
    check("ar_fu_valid", 128'(fu_valid), 128'(0));
    check("ar_lane_cnt", 128'(lane_cnt), 128'(0));
    check("ar_rs_avail", 128'(rs_avail), 128'(3'b111));
    #1; rst_n = 1'b1;
    cyc();
    check("ar_post_fu_valid", 128'(fu_valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
